// File: rtl/palette_lut_banked_pkg.sv
// Shared definitions for the double-buffered palette lookup: controller states,
// channel indices and the transparent color index.
package palette_lut_banked_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACK  = 2'd2
    } ctrl_state_e;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int CH_X = 3;

    localparam int TRANSPARENT_IDX = 0;

    localparam int SW = 2;

endpackage

// File: rtl/palette_bank_ram.sv
// Single-channel, single-bank palette storage: one write port with registered
// read-back (old data on a same-cycle write) and one registered read-only port.
module palette_bank_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [DW-1:0] b_rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    // NOTE: the array and read registers carry no reset; the top level clears
    // every entry with its post-reset sweep, and a reset would block RAM mapping.
    always_ff @(posedge clk) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        a_rdata_q <= mem_q[a_addr_i];
        b_rdata_q <= mem_q[b_addr_i];
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/palette_lut_banked.sv
// Double-buffered palette lookup: controller access FSM with post-reset clear
// sweep, frame-aligned bank swap, and a 2-cycle pixel lookup pipeline.
module palette_lut_banked
    import palette_lut_banked_pkg::*;
#(
    parameter int LAYERS = 32,
    parameter int COLORS = 32,
    parameter int NUM_CH = 3,
    parameter int CH_W   = 16,
    parameter int OUT_W  = 8,
    localparam int LW    = $clog2(LAYERS),
    localparam int CW    = $clog2(COLORS),
    localparam int PW    = NUM_CH * OUT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ctrlReq,
    input  logic            ctrlWe,
    input  logic [LW-1:0]   ctrlLayer,
    input  logic [CW-1:0]   ctrlColor,
    input  logic [SW-1:0]   ctrlChan,
    input  logic [CH_W-1:0] ctrlWrData,
    output logic            ctrlAck,
    output logic [CH_W-1:0] ctrlRdData,
    input  logic            swapReq,
    input  logic            frameStart,
    output logic            swapPending,
    output logic            activeBank,
    output logic            initBusy,
    input  logic            pipeValid,
    input  logic [LW-1:0]   pipeLayer,
    input  logic [CW-1:0]   pipeColor,
    output logic            pipeValidOut,
    output logic [PW-1:0]   pipeRgb,
    output logic            pixelFound
);

    localparam int AW    = LW + CW;
    localparam int DEPTH = LAYERS * COLORS;

    ctrl_state_e     state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            ctrl_bank_q, ctrl_bank_d;
    logic [SW-1:0]   ctrl_chan_q, ctrl_chan_d;
    logic            ctrl_wr_en;
    logic            bank_q, bank_d;
    logic            pending_q, pending_d;
    logic            init_busy;

    logic            s1_valid_q, s1_bank_q, s1_opaque_q, s1_init_q;
    logic [AW-1:0]   s1_addr_q;
    logic            s2_valid_q, s2_bank_q, s2_opaque_q, s2_init_q;

    logic [CH_W-1:0] a_rd [2][NUM_CH];
    logic [CH_W-1:0] b_rd [2][NUM_CH];
    logic [CH_W-1:0] ctrl_rd_mux;
    logic [PW-1:0]   pix_rgb;

    assign init_busy = (state_q == ST_INIT);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ctrl_bank_d = ctrl_bank_q;
        ctrl_chan_d = ctrl_chan_q;
        ctrl_wr_en  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ctrlReq) begin
                    state_d     = ST_ACK;
                    ctrl_bank_d = ~bank_q;
                    ctrl_chan_d = ctrlChan;
                    ctrl_wr_en  = ctrlWe && (ctrlColor != CW'(TRANSPARENT_IDX));
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // A swap can only land once the clear sweep is done; otherwise it stays pending.
    always_comb begin
        bank_d    = bank_q;
        pending_d = pending_q;
        if (frameStart && (pending_q || swapReq) && !init_busy) begin
            bank_d    = ~bank_q;
            pending_d = 1'b0;
        end else if (swapReq) begin
            pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            ctrl_bank_q <= 1'b0;
            ctrl_chan_q <= '0;
            bank_q      <= 1'b0;
            pending_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_bank_q   <= 1'b0;
            s1_opaque_q <= 1'b0;
            s1_init_q   <= 1'b0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_bank_q   <= 1'b0;
            s2_opaque_q <= 1'b0;
            s2_init_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ctrl_bank_q <= ctrl_bank_d;
            ctrl_chan_q <= ctrl_chan_d;
            bank_q      <= bank_d;
            pending_q   <= pending_d;
            s1_valid_q  <= pipeValid;
            s1_bank_q   <= bank_q;
            s1_opaque_q <= (pipeColor != CW'(TRANSPARENT_IDX));
            s1_init_q   <= init_busy;
            s1_addr_q   <= {pipeLayer, pipeColor};
            s2_valid_q  <= s1_valid_q;
            s2_bank_q   <= s1_bank_q;
            s2_opaque_q <= s1_opaque_q;
            s2_init_q   <= s1_init_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
            logic            wr_en;
            logic [AW-1:0]   a_addr;
            logic [CH_W-1:0] a_wdata;

            // The sweep clears both banks and all channels at once.
            assign wr_en   = init_busy ||
                             (ctrl_wr_en && (ctrl_bank_d == 1'(b)) && (ctrlChan == SW'(ch)));
            assign a_addr  = init_busy ? clr_cnt_q : {ctrlLayer, ctrlColor};
            assign a_wdata = init_busy ? '0 : ctrlWrData;

            palette_bank_ram #(
                .DEPTH (DEPTH),
                .AW    (AW),
                .DW    (CH_W)
            ) u_ram (
                .clk       (clk),
                .a_we_i    (wr_en),
                .a_addr_i  (a_addr),
                .a_wdata_i (a_wdata),
                .a_rdata_o (a_rd[b][ch]),
                .b_addr_i  (s1_addr_q),
                .b_rdata_o (b_rd[b][ch])
            );
        end
    end

    always_comb begin
        ctrl_rd_mux = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ctrl_chan_q == SW'(ch)) begin
                ctrl_rd_mux = a_rd[ctrl_bank_q][ch];
            end
        end
    end

    always_comb begin
        pix_rgb = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pix_rgb[(NUM_CH-1-ch)*OUT_W +: OUT_W] = b_rd[s2_bank_q][ch][CH_W-1 -: OUT_W];
        end
    end

    assign ctrlAck      = (state_q == ST_ACK);
    assign ctrlRdData   = ctrlAck ? ctrl_rd_mux : '0;
    assign swapPending  = pending_q;
    assign activeBank   = bank_q;
    assign initBusy     = init_busy;
    assign pipeValidOut = s2_valid_q;
    assign pipeRgb      = (s2_valid_q && s2_opaque_q && !s2_init_q) ? pix_rgb : '0;
    assign pixelFound   = s2_valid_q && s2_opaque_q;

endmodule

// File: tb/tb_palette_lut_banked.sv
// Scoreboard bench for palette_lut_banked: a behavioural palette model predicts
// every pixel and controller response; a monitor compares as outputs appear.
module tb_palette_lut_banked;
    import palette_lut_banked_pkg::*;

    localparam int LAYERS = 32;
    localparam int COLORS = 32;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 16;
    localparam int OUT_W  = 8;
    localparam int LW     = 5;
    localparam int CW     = 5;
    localparam int DEPTH  = LAYERS * COLORS;
    localparam int PW     = NUM_CH * OUT_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            ctrlReq, ctrlWe;
    logic [LW-1:0]   ctrlLayer;
    logic [CW-1:0]   ctrlColor;
    logic [1:0]      ctrlChan;
    logic [CH_W-1:0] ctrlWrData;
    logic            ctrlAck;
    logic [CH_W-1:0] ctrlRdData;
    logic            swapReq, frameStart;
    logic            swapPending, activeBank, initBusy;
    logic            pipeValid;
    logic [LW-1:0]   pipeLayer;
    logic [CW-1:0]   pipeColor;
    logic            pipeValidOut;
    logic [PW-1:0]   pipeRgb;
    logic            pixelFound;

    always #5 clk = ~clk;

    palette_lut_banked #(
        .LAYERS (LAYERS), .COLORS (COLORS), .NUM_CH (NUM_CH), .CH_W (CH_W), .OUT_W (OUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrlReq      (ctrlReq),
        .ctrlWe       (ctrlWe),
        .ctrlLayer    (ctrlLayer),
        .ctrlColor    (ctrlColor),
        .ctrlChan     (ctrlChan),
        .ctrlWrData   (ctrlWrData),
        .ctrlAck      (ctrlAck),
        .ctrlRdData   (ctrlRdData),
        .swapReq      (swapReq),
        .frameStart   (frameStart),
        .swapPending  (swapPending),
        .activeBank   (activeBank),
        .initBusy     (initBusy),
        .pipeValid    (pipeValid),
        .pipeLayer    (pipeLayer),
        .pipeColor    (pipeColor),
        .pipeValidOut (pipeValidOut),
        .pipeRgb      (pipeRgb),
        .pixelFound   (pixelFound)
    );

    typedef struct { logic [PW-1:0] rgb; logic found; } pix_t;
    typedef struct { logic is_rd; logic [CH_W-1:0] data; } acc_t;

    pix_t            pix_q[$];
    acc_t            acc_q[$];
    logic [CH_W-1:0] mdl [2][NUM_CH][DEPTH];
    logic            m_bank, m_pending;
    int              cyc;
    bit              ctrl_issue;
    int              n_chk = 0;
    int              n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int a = 0; a < DEPTH; a++) mdl[b][ch][a] = '0;
        m_bank = 1'b0; m_pending = 1'b0; cyc = 0; ctrl_issue = 1'b0;
        pix_q.delete(); acc_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},      ctrlAck, 0);
        check({tag, "_rd_data"},  ctrlRdData, 0);
        check({tag, "_pending"},  swapPending, 0);
        check({tag, "_bank"},     activeBank, 0);
        check({tag, "_init"},     initBusy, 1);
        check({tag, "_valid"},    pipeValidOut, 0);
        check({tag, "_rgb"},      pipeRgb, 0);
        check({tag, "_found"},    pixelFound, 0);
    endtask

    // Model the effect of the coming clock edge, then advance to the next falling edge.
    task automatic tick();
        logic [LW+CW-1:0] a;
        logic             m_init;
        pix_t             p;
        acc_t             e;
        m_init = (cyc < DEPTH);
        if (ctrl_issue) begin
            ctrl_issue = 1'b0;
            a = {ctrlLayer, ctrlColor};
            e.is_rd = !ctrlWe;
            e.data  = '0;
            if (ctrlWe) begin
                if (ctrlColor != 0 && ctrlChan < NUM_CH) mdl[!m_bank][ctrlChan][a] = ctrlWrData;
            end else if (ctrlChan < NUM_CH) begin
                e.data = mdl[!m_bank][ctrlChan][a];
            end
            acc_q.push_back(e);
        end
        if (pipeValid) begin
            a = {pipeLayer, pipeColor};
            p.found = (pipeColor != 0);
            p.rgb   = '0;
            if (p.found && !m_init)
                for (int ch = 0; ch < NUM_CH; ch++)
                    p.rgb[(NUM_CH-1-ch)*OUT_W +: OUT_W] = mdl[m_bank][ch][a][CH_W-1 -: OUT_W];
            pix_q.push_back(p);
        end
        if (swapReq) m_pending = 1'b1;
        if (frameStart && m_pending && !m_init) begin
            m_bank    = !m_bank;
            m_pending = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        swapReq    = 1'b0;
        frameStart = 1'b0;
        check("active_bank",  activeBank,  m_bank);
        check("swap_pending", swapPending, m_pending);
        check("init_busy",    initBusy,    cyc < DEPTH);
    endtask

    task automatic ctrl_access(input logic we, input logic [LW-1:0] l, input logic [CW-1:0] c,
                               input logic [1:0] ch, input logic [CH_W-1:0] d);
        int waited;
        ctrlReq = 1'b1; ctrlWe = we; ctrlLayer = l; ctrlColor = c; ctrlChan = ch; ctrlWrData = d;
        ctrl_issue = 1'b1;
        tick();
        waited = 0;
        while (!ctrlAck && waited < 8) begin
            tick();
            waited++;
        end
        check("ctrl_ack_latency", waited, 0);
        ctrlReq = 1'b0;
        tick();
    endtask

    task automatic rand_step();
        pipeValid  = ($urandom_range(0, 3) != 0);
        pipeLayer  = LW'($urandom_range(0, 3));
        pipeColor  = CW'($urandom_range(0, 7));
        swapReq    = ($urandom_range(0, 15) == 0);
        frameStart = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 2) == 0)
            ctrl_access(1'($urandom_range(0, 1)), LW'($urandom_range(0, 3)), CW'($urandom_range(0, 7)),
                        2'($urandom_range(0, 3)), 16'($urandom));
        else
            tick();
    endtask

    task automatic wait_init(output int n_busy, input bit swap_in_init);
        int i;
        n_busy = 0;
        i = 0;
        while (initBusy && i < 3000) begin
            n_busy++;
            if (swap_in_init && i == 10) swapReq = 1'b1;
            if (swap_in_init && i == 20) frameStart = 1'b1;
            tick();
            i++;
        end
    endtask

    // Scoreboard monitor: compares whatever the DUT presents against the queued predictions.
    always @(negedge clk) begin : monitor
        pix_t p;
        acc_t e;
        if (rst) begin
            if (pipeValidOut) begin
                if (pix_q.size() == 0) check("pipe_unexpected", 1, 0);
                else begin
                    p = pix_q.pop_front();
                    check("pipe_rgb", pipeRgb, p.rgb);
                    check("pixel_found", pixelFound, p.found);
                end
            end else begin
                check("pipe_idle", {pipeRgb, pixelFound}, 0);
            end
            if (ctrlAck) begin
                if (acc_q.size() == 0) check("ack_unexpected", 1, 0);
                else begin
                    e = acc_q.pop_front();
                    if (e.is_rd) check("ctrl_rd_data", ctrlRdData, e.data);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2ms", $time);
        $fatal(1);
    end

    initial begin
        int  n_busy, gaps;
        bit  ack_seen;
        rst = 1'b0; ctrlReq = 0; ctrlWe = 0; ctrlLayer = 0; ctrlColor = 0; ctrlChan = 0;
        ctrlWrData = 0; swapReq = 0; frameStart = 0; pipeValid = 0; pipeLayer = 0; pipeColor = 0;
        clear_model();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Clear sweep: requests ignored, exactly DEPTH busy cycles.
        ctrlReq = 1'b1; ctrlWe = 1'b0; ctrlLayer = 3; ctrlColor = 5; ctrlChan = CH_R;
        ack_seen = 1'b0;
        n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            n_busy += int'(initBusy);
            tick();
            ack_seen |= ctrlAck;
        end
        ctrlReq = 1'b0;
        check("no_ack_during_init", ack_seen, 0);
        begin
            int rest;
            wait_init(rest, 1'b0);
            check("init_cycles", n_busy + rest, DEPTH);
        end
        ctrl_access(1'b0, 3, 5, 2'(CH_R), 0);

        // Write shadow bank, swap on frame boundary, look it up.
        ctrl_access(1'b1, 2, 7, 2'(CH_R), 16'hABCD);
        swapReq = 1'b1;
        tick();
        check("pending_set", swapPending, 1);
        frameStart = 1'b1;
        tick();
        check("swap_applied", activeBank, 1);
        pipeValid = 1'b1; pipeLayer = 2; pipeColor = 7;
        tick();
        pipeValid = 1'b0;
        check("latency_1", pipeValidOut, 0);
        tick();
        check("latency_2", pipeValidOut, 1);
        check("rgb_red", pipeRgb[23:16], 8'hAB);
        check("found_opaque", pixelFound, 1);

        // Transparent slot: writes ignored, lookups transparent.
        ctrl_access(1'b1, 2, 0, 2'(CH_G), 16'h1234);
        ctrl_access(1'b0, 2, 0, 2'(CH_G), 0);
        ctrl_access(1'b0, 2, 7, 2'(CH_X), 0);
        pipeValid = 1'b1; pipeLayer = 2; pipeColor = 0;
        tick();
        pipeValid = 1'b0;
        tick();
        check("transp_valid", pipeValidOut, 1);
        check("transp_rgb", pipeRgb, 0);
        check("transp_found", pixelFound, 0);

        // Continuous stream across a swap.
        for (int ch = 0; ch < NUM_CH; ch++) ctrl_access(1'b1, 1, 1, 2'(ch), 16'h1100 + 16'(ch * 16'h2211));
        gaps = 0;
        pipeLayer = 1; pipeColor = 1;
        for (int i = 0; i < 12; i++) begin
            pipeValid = 1'b1;
            if (i == 2) swapReq = 1'b1;
            if (i == 6) frameStart = 1'b1;
            tick();
            if (i >= 1 && !pipeValidOut) gaps++;
        end
        pipeValid = 1'b0;
        check("stream_gaps", gaps, 0);

        for (int i = 0; i < 300; i++) rand_step();

        // Reset while in ACK with the pipeline full.
        pipeValid = 1'b0; swapReq = 1'b0; frameStart = 1'b0;
        if (!m_bank) begin
            swapReq = 1'b1; frameStart = 1'b1;
            tick();
        end
        pipeValid = 1'b1; pipeLayer = 1; pipeColor = 1;
        tick();
        tick();
        ctrlReq = 1'b1; ctrlWe = 1'b0; ctrlLayer = 1; ctrlColor = 1; ctrlChan = CH_G;
        ctrl_issue = 1'b1;
        tick();
        check("pre_reset_ack", ctrlAck, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        ctrlReq = 1'b0; pipeValid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_init(n_busy, 1'b1);
        check("reinit_cycles", n_busy, DEPTH);
        check("init_swap_pending", swapPending, 1);
        check("init_swap_bank", activeBank, 0);
        frameStart = 1'b1;
        tick();
        check("post_init_swap_bank", activeBank, 1);
        check("post_init_swap_pending", swapPending, 0);

        for (int i = 0; i < 150; i++) rand_step();

        pipeValid = 1'b0; swapReq = 1'b0; frameStart = 1'b0;
        repeat (4) tick();
        check("pix_queue_drained", pix_q.size(), 0);
        check("acc_queue_drained", acc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/palette_lut_banked.md
# palette_lut_banked

Parametrised, double-buffered palette lookup for pipeline stage 4. It maps a (layer, color index) pair from the pixel pipeline to a packed RGB output with a transparency flag, using a registered 2-cycle pipeline. The controller writes and reads a shadow bank through a req/ack handshake. A requested bank swap takes effect only on a frame boundary, and both banks are hardware-cleared after reset.

## Interface
Parameters:
- LAYERS, 32, number of layers (power of 2)
- COLORS, 32, color slots per layer (power of 2); slot 0 is transparent
- NUM_CH, 3, color channels per entry (1..4)
- CH_W, 16, stored bits per channel
- OUT_W, 8, output bits per channel (≤ CH_W; MSBs of stored value)

Derived widths: LW = clog2(LAYERS), CW = clog2(COLORS), SW = 2.

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- ctrlReq  in  1  controller access request; held until ctrlAck
- ctrlWe  in  1  1 = write, 0 = read
- ctrlLayer  in  LW  layer select
- ctrlColor  in  CW  color slot select
- ctrlChan  in  SW  channel select
- ctrlWrData  in  CH_W  write data
- ctrlAck  out  1  one-cycle completion pulse
- ctrlRdData  out  CH_W  read data, valid while ctrlAck
- swapReq  in  1  pulse; request a bank swap
- frameStart  in  1  pulse; frame boundary
- swapPending  out  1  swap requested, not yet applied
- activeBank  out  1  bank read by the pipeline
- initBusy  out  1  clear sweep in progress
- pipeValid  in  1  pipeline input valid
- pipeLayer  in  LW  pipeline layer
- pipeColor  in  CW  pipeline color index
- pipeValidOut  out  1  output valid
- pipeRgb  out  NUM_CH*OUT_W  packed color; channel 0 in the MSBs
- pixelFound  out  1  non-transparent pixel

## Operation
- Storage: 2 banks × NUM_CH channels × LAYERS*COLORS entries × CH_W bits. Address = {layer, color}.
- Controller FSM has three states: INIT, IDLE, ACK.
- INIT:
  - Entered on reset.
  - A counter sweeps all LAYERS*COLORS addresses and writes zero to every bank and channel in parallel, one address per cycle.
  - initBusy = 1 throughout; ctrlReq is ignored.
  - Exits to IDLE after the last address.
- IDLE:
  - On ctrlReq = 1, sample layer, color, channel, data, we and the shadow bank (= ~activeBank). Go to ACK.
  - A write is performed only if ctrlColor != 0 and ctrlChan < NUM_CH; otherwise it is ignored.
  - A read returns 0 if ctrlChan ≥ NUM_CH. Slot 0 reads return the stored value, which is always 0.
- ACK:
  - ctrlAck = 1 for one cycle, with ctrlRdData valid. Return to IDLE.
  - Back-to-back requests: at most one access per 2 cycles.
- Swap:
  - swapReq sets swapPending.
  - On frameStart with (swapPending or swapReq) and initBusy = 0: toggle activeBank and clear swapPending.
  - frameStart during INIT: the swap stays pending.
- Controller accesses always target the bank sampled in IDLE, even if a swap lands during ACK.
- Pipeline:
  - Stage 1 registers pipeValid, the address, activeBank and (pipeColor != 0).
  - Stage 2 registers the RAM read of that bank.
  - pipeRgb = concatenation of the top OUT_W bits of channels 0..NUM_CH-1.
  - pipeRgb is forced to 0 when pipeValidOut = 0, when the index is transparent, or when initBusy was set at stage 1.
  - pixelFound = pipeValidOut && index != 0.
- No backpressure: the pipeline accepts a pixel every cycle.

## Timing
- Reset values: ctrlAck = 0, ctrlRdData = 0, swapPending = 0, activeBank = 0, initBusy = 1, pipeValidOut = 0, pipeRgb = 0, pixelFound = 0. Stage registers are cleared.
- INIT lasts exactly LAYERS*COLORS cycles after reset deassertion. initBusy falls on the following edge.
- Controller timing: req is sampled at edge N, ctrlAck is high during cycle N+1, and the write is visible to any access issued from edge N+1.
- Pipeline latency is 2 clocks from pipeValid to pipeValidOut.
- Bank selection:
  - The bank is captured at stage 1, so in-flight pixels complete on their issue bank.
  - activeBank changes on the edge after frameStart.
  - Pixels issued in the same cycle as frameStart use the old bank.
- Reset asserted mid-operation: everything returns to reset values immediately, and the full INIT sweep restarts. In-flight pixels and accesses are dropped; no ack is issued.

## Structure
- A shared package holds:
  - state encodings for INIT, IDLE and ACK
  - channel index constants (R = 0, G = 1, B = 2, X = 3)
  - the transparent index constant (0)
- One sub-module, palette_bank_ram: a single-channel, single-bank RAM with one write port and a registered read port. It is instantiated 2*NUM_CH times.
- The top level contains the FSM, the clear counter, the swap logic and the pipeline registers.

## Test plan
- Reset release, defaults (LAYERS = 32, COLORS = 32) -> initBusy high exactly 1024 cycles. A read of layer 3, color 5, channel 0 afterwards returns 0, and ctrlReq is not acked during INIT.
- Write 0xABCD to layer 2, color 7, channel R; swapReq; frameStart -> activeBank = 1. A pipeline pixel at (2, 7) yields pipeRgb[23:16] = 0xAB and pixelFound = 1, two cycles after pipeValid.
- Write 0x1234 to color 0 -> acked, but a readback returns 0. A pipeline pixel at color 0 yields pipeRgb = 0 and pixelFound = 0.
- Stream pixels continuously across frameStart with a pending swap -> pixels issued on or before the frameStart cycle show old-bank data, and later pixels show new-bank data with no gap in pipeValidOut.
- swapReq during INIT plus frameStart during INIT -> swapPending stays 1 and activeBank stays 0. The swap applies at the first frameStart after initBusy falls.
- Assert rst while ctrlReq is held in ACK and the pipeline is full -> all outputs go to 0 immediately, initBusy = 1, activeBank = 0, and the INIT sweep reruns for the full duration.
